overlap_add_512: RTL and testbench

Synthesis-side counterpart of the HPSS 512-point framing stage. It reads one reconstructed 512-sample frame from the iFFT/modulation result memory. It overlap-adds the first half with the stored second half of the previous frame (hop 256) and streams 256 saturated samples per frame toward the HPSS output FIFO. The top-level HPSS controller issues one `start` per frame and waits for `done`.

---
 rtl/overlap_add_if.sv | 30 +++
 rtl/overlap_add_512.sv | 153 +++++++++++++++
 tb/tb_overlap_add_512.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/overlap_add_if.sv
// Handshake and data bus of the overlap-add stage: controller strobes,
// frame memory read port and the output stream toward the output FIFO.
interface overlap_add_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 9
);
  logic                         start;
  logic                         flush;
  logic                         busy;
  logic                         done;
  logic                         frm_rd_en;
  logic [ADDR_W-1:0]            frm_addr;
  logic signed [DATA_WIDTH-1:0] frm_data;
  logic                         out_ready;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic [15:0]                  frame_cnt;

  // controller/memory/sink side
  modport master (
    output start, flush, frm_data, out_ready,
    input  busy, done, frm_rd_en, frm_addr, out_valid, out_data, frame_cnt
  );

  // overlap-add block side
  modport slave (
    input  start, flush, frm_data, out_ready,
    output busy, done, frm_rd_en, frm_addr, out_valid, out_data, frame_cnt
  );
endinterface

// File: rtl/overlap_add_512.sv
// Overlap-add of a 512-sample reconstructed frame at hop 256. The head half
// of each frame is summed with the stored tail of the previous frame and
// streamed out saturated; the tail half is then captured for the next frame.
module overlap_add_512 #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 512,
  parameter int HOP        = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  overlap_add_if.slave bus
);
  localparam int AW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(HOP);
  localparam logic [HW:0] LAST_HEAD = (HW+1)'(HOP - 1);
  localparam logic [HW:0] HOP_CNT   = (HW+1)'(HOP);

  typedef enum logic [1:0] {IDLE, HEAD, TAIL, DONE} state_t;

  state_t          state_q, state_d;
  logic [HW:0]     idx_q, idx_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tail_valid_q, tail_valid_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  // read-return pipeline: which half the in-flight read belongs to
  logic            out_valid_q;
  logic            tail_we_q;
  logic [HW-1:0]   wr_idx_q;

  logic [DATA_WIDTH-1:0] tail_mem [HOP];
  logic [DATA_WIDTH-1:0] tail_rd_q;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] sat_val;

  // Next-state logic. Outputs are registered, so this decides the read that
  // happens in the following cycle, using the current out_ready.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rd_en_d      = 1'b0;
    addr_d       = addr_q;
    done_d       = 1'b0;
    tail_valid_d = tail_valid_q;
    frame_cnt_d  = frame_cnt_q;
    case (state_q)
      IDLE: begin
        // flush takes effect before a same-cycle start
        if (bus.flush) tail_valid_d = 1'b0;
        if (bus.start) begin
          state_d = HEAD;
          idx_d   = '0;
          if (bus.out_ready) begin
            rd_en_d = 1'b1;
            addr_d  = '0;
            idx_d   = (HW+1)'(1);
          end
        end
      end
      HEAD: begin
        if (bus.out_ready) begin
          rd_en_d = 1'b1;
          addr_d  = AW'(idx_q);
          if (idx_q == LAST_HEAD) begin
            state_d = TAIL;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      TAIL: begin
        // idx reaching HOP means all tail reads are issued; the last one
        // returns together with done
        if (idx_q < HOP_CNT) begin
          rd_en_d = 1'b1;
          addr_d  = AW'(HOP) + AW'(idx_q);
          idx_d   = idx_q + 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d      = IDLE;
        tail_valid_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control registers and read-return pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tail_valid_q <= 1'b0;
      frame_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      tail_we_q    <= 1'b0;
      wr_idx_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tail_valid_q <= tail_valid_d;
      frame_cnt_q  <= frame_cnt_d;
      out_valid_q  <= rd_en_q && !addr_q[AW-1];
      tail_we_q    <= rd_en_q && addr_q[AW-1];
      wr_idx_q     <= addr_q[HW-1:0];
    end
  end

  // Tail buffer: synchronous RAM read alongside the head read so the entry
  // lines up with frm_data; written one cycle after each tail read.
  always_ff @(posedge clk) begin
    if (tail_we_q) tail_mem[wr_idx_q] <= bus.frm_data;
    tail_rd_q <= tail_mem[addr_q[HW-1:0]];
  end

  // Widened sum and clip; overflow shows as differing top two bits.
  always_comb begin
    sum = {bus.frm_data[DATA_WIDTH-1], bus.frm_data}
        + (tail_valid_q ? {tail_rd_q[DATA_WIDTH-1], tail_rd_q} : '0);
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
      sat_val = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      sat_val = sum[DATA_WIDTH-1:0];
  end

  // The frame memory's output register is the data stage: out_data is
  // formed from it in the cycle out_valid is high and forced to 0 otherwise.
  assign bus.frm_rd_en = rd_en_q;
  assign bus.frm_addr  = addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_valid_q ? sat_val : '0;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_overlap_add_512.sv
// Bench for overlap_add_512: frame memory model, frame-level reference model
// and one task per scenario.
module tb_overlap_add_512;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  overlap_add_if #(.DATA_WIDTH(16), .ADDR_W(9)) bus ();
  overlap_add_512 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  // frame memory: registered read, data one cycle after frm_rd_en
  logic signed [15:0] mem [512];
  always @(posedge clk) if (bus.frm_rd_en) bus.frm_data <= mem[bus.frm_addr];

  // reference model state
  int prev [256];
  bit tv;
  int mcnt;
  int exp_v [256];

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // expected outputs of the next frame, then advance model state
  task automatic model_frame();
    for (int n = 0; n < 256; n++) exp_v[n] = sat(int'(mem[n]) + (tv ? prev[n] : 0));
    for (int n = 0; n < 256; n++) prev[n] = int'(mem[256 + n]);
    tv = 1'b1;
    mcnt = (mcnt + 1) % 65536;
  endtask

  // observations of the last frame
  int obs[$];
  int done_cyc, done_pulses, first_v, last_v;
  logic busy_at0, busy_at1, busy_after;

  // Runs one frame; must be called at a negedge (that cycle is cycle 0).
  // out_ready is low in cycles lo..hi; start re-pulsed at cycle extra_at.
  task automatic run_frame(input int lo, input int hi, input bit with_flush, input int extra_at);
    int cyc;
    obs.delete();
    done_cyc = -1; done_pulses = 0; first_v = -1; last_v = -1;
    busy_after = 1'bx; busy_at1 = 1'bx;
    cyc = 0;
    busy_at0 = bus.busy;
    bus.start = 1'b1; bus.flush = with_flush;
    bus.out_ready = !(cyc >= lo && cyc <= hi);
    while (cyc < 1500) begin
      @(negedge clk); cyc++;
      bus.start = (cyc == extra_at); bus.flush = 1'b0;
      bus.out_ready = !(cyc >= lo && cyc <= hi);
      if (cyc == 1) busy_at1 = bus.busy;
      if (bus.out_valid) begin
        obs.push_back(int'(bus.out_data));
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (bus.done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = bus.busy;
        break;
      end
    end
    bus.start = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 0; bus.flush = 0; bus.out_ready = 1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.frm_rd_en, bus.out_valid} !== 4'b0 ||
        bus.out_data !== 16'sd0 || bus.frm_addr !== 9'd0 || bus.frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b rd=%b vld=%b data=%0d addr=%0d cnt=%0d exp all 0",
               bus.busy, bus.done, bus.frm_rd_en, bus.out_valid, bus.out_data, bus.frm_addr, bus.frame_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.frm_rd_en !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset got busy=%b rd=%b exp 0 0", bus.busy, bus.frm_rd_en);
    end
    tv = 0; mcnt = 0;
  endtask

  task automatic test_first_frame();
    for (int n = 0; n < 512; n++) mem[n] = 16'(n);
    model_frame();
    run_frame(-1, -1, 0, -1);
    total++; if (busy_at0 !== 1'b0) begin bad++; $display("FAIL busy_cycle0 got=%b exp=0", busy_at0); end
    total++; if (busy_at1 !== 1'b1) begin bad++; $display("FAIL busy_cycle1 got=%b exp=1", busy_at1); end
    total++; if (first_v != 2) begin bad++; $display("FAIL first_valid_cycle got=%0d exp=2", first_v); end
    total++; if (last_v != 257) begin bad++; $display("FAIL last_valid_cycle got=%0d exp=257", last_v); end
    total++; if (done_cyc != 513) begin bad++; $display("FAIL done_cycle got=%0d exp=513", done_cyc); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL busy_cycle514 got=%b exp=0", busy_after); end
    total++; if (obs.size() != 256) begin bad++; $display("FAIL ramp_count got=%0d exp=256", obs.size()); end
    for (int n = 0; n < 256; n++) begin
      total++;
      if (n >= obs.size() || obs[n] != exp_v[n] || exp_v[n] != n) begin
        bad++; $display("FAIL ramp_sample[%0d] got=%0d exp=%0d", n, (n < obs.size()) ? obs[n] : -99999, n);
      end
    end
    total++; if (bus.frame_cnt !== 16'd1) begin bad++; $display("FAIL frame_cnt_first got=%0d exp=1", bus.frame_cnt); end
  endtask

  task automatic test_second_frame();
    for (int n = 0; n < 512; n++) mem[n] = 16'sd100;
    model_frame();
    run_frame(-1, -1, 0, -1);
    total++; if (done_cyc != 513) begin bad++; $display("FAIL b2b_done_cycle got=%0d exp=513", done_cyc); end
    for (int n = 0; n < 256; n++) begin
      total++;
      if (n >= obs.size() || obs[n] != exp_v[n] || obs[n] != 356 + n) begin
        bad++; $display("FAIL const_sample[%0d] got=%0d exp=%0d", n, (n < obs.size()) ? obs[n] : -99999, 356 + n);
      end
    end
    total++; if (bus.frame_cnt !== 16'd2) begin bad++; $display("FAIL frame_cnt_second got=%0d exp=2", bus.frame_cnt); end
  endtask

  task automatic test_saturation();
    int vals [4] = '{30000, 30000, -30000, -30000};
    for (int f = 0; f < 4; f++) begin
      for (int n = 0; n < 512; n++) mem[n] = 16'(vals[f]);
      model_frame();
      run_frame(-1, -1, 0, -1);
      if (f == 1 || f == 3) begin
        total++;
        if (obs.size() != 256) begin bad++; $display("FAIL sat_count got=%0d exp=256", obs.size()); end
        for (int n = 0; n < 256; n++) begin
          total++;
          if (n >= obs.size() || obs[n] != exp_v[n] || obs[n] != ((f == 1) ? 32767 : -32768)) begin
            bad++; $display("FAIL sat_sample[%0d] got=%0d exp=%0d", n, (n < obs.size()) ? obs[n] : -99999, exp_v[n]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 512; n++) mem[n] = 16'(n * 3 - 700);
    model_frame();
    run_frame(10, 19, 0, -1);
    total++; if (done_cyc != 523) begin bad++; $display("FAIL bp_done_cycle got=%0d exp=523", done_cyc); end
    total++; if (obs.size() != 256) begin bad++; $display("FAIL bp_count got=%0d exp=256", obs.size()); end
    for (int n = 0; n < 256; n++) begin
      total++;
      if (n >= obs.size() || obs[n] != exp_v[n]) begin
        bad++; $display("FAIL bp_sample[%0d] got=%0d exp=%0d", n, (n < obs.size()) ? obs[n] : -99999, exp_v[n]);
      end
    end
    // out_ready low during the tail phase must not stretch the frame
    model_frame();
    run_frame(300, 320, 0, -1);
    total++; if (done_cyc != 513) begin bad++; $display("FAIL tail_ignores_ready got=%0d exp=513", done_cyc); end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      int lo, len;
      for (int n = 0; n < 512; n++) mem[n] = 16'($urandom);
      lo = $urandom_range(5, 150); len = $urandom_range(1, 20);
      model_frame();
      run_frame(lo, lo + len - 1, 0, -1);
      total++; if (done_cyc != 513 + len) begin bad++; $display("FAIL rnd_done_cycle got=%0d exp=%0d", done_cyc, 513 + len); end
      for (int n = 0; n < 256; n++) begin
        total++;
        if (n >= obs.size() || obs[n] != exp_v[n]) begin
          bad++; $display("FAIL rnd_sample[%0d] got=%0d exp=%0d", n, (n < obs.size()) ? obs[n] : -99999, exp_v[n]);
        end
      end
      total++; if (bus.frame_cnt !== 16'(mcnt)) begin bad++; $display("FAIL rnd_frame_cnt got=%0d exp=%0d", bus.frame_cnt, mcnt); end
    end
  endtask

  task automatic test_flush();
    // flush alone in IDLE, then a ramp frame with a stray start mid-frame
    bus.flush = 1'b1; @(negedge clk); bus.flush = 1'b0; tv = 0;
    for (int n = 0; n < 512; n++) mem[n] = 16'(n);
    model_frame();
    run_frame(-1, -1, 0, 50);
    total++; if (done_cyc != 513 || done_pulses != 1) begin
      bad++; $display("FAIL flush_done got cycle=%0d pulses=%0d exp cycle=513 pulses=1", done_cyc, done_pulses);
    end
    total++; if (bus.frame_cnt !== 16'(mcnt)) begin bad++; $display("FAIL flush_frame_cnt got=%0d exp=%0d", bus.frame_cnt, mcnt); end
    for (int n = 0; n < 256; n++) begin
      total++;
      if (n >= obs.size() || obs[n] != n) begin
        bad++; $display("FAIL flush_sample[%0d] got=%0d exp=%0d", n, (n < obs.size()) ? obs[n] : -99999, n);
      end
    end
    // flush and start in the same cycle: new frame sees an empty tail
    for (int n = 0; n < 512; n++) mem[n] = 16'(1000 - n);
    tv = 0;
    model_frame();
    run_frame(-1, -1, 1, -1);
    for (int n = 0; n < 256; n++) begin
      total++;
      if (n >= obs.size() || obs[n] != exp_v[n] || obs[n] != 1000 - n) begin
        bad++; $display("FAIL flush_start_sample[%0d] got=%0d exp=%0d", n, (n < obs.size()) ? obs[n] : -99999, 1000 - n);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    for (int n = 0; n < 512; n++) mem[n] = 16'sd5000;
    bus.start = 1'b1; bus.out_ready = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk); bus.start = 1'b0;
      if (bus.done) dones++;
    end
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
      total++;
      if ({bus.busy, bus.done, bus.frm_rd_en, bus.out_valid} !== 4'b0 ||
          bus.out_data !== 16'sd0 || bus.frm_addr !== 9'd0 || bus.frame_cnt !== 16'd0) begin
        bad++;
        $display("FAIL midreset_outputs got busy=%b done=%b rd=%b vld=%b data=%0d addr=%0d cnt=%0d exp all 0",
                 bus.busy, bus.done, bus.frm_rd_en, bus.out_valid, bus.out_data, bus.frm_addr, bus.frame_cnt);
      end
    end
    total++; if (dones != 0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
    rst_n = 1'b1; tv = 0; mcnt = 0;
    @(negedge clk);
    for (int n = 0; n < 512; n++) mem[n] = 16'(n);
    model_frame();
    run_frame(-1, -1, 0, -1);
    for (int n = 0; n < 256; n++) begin
      total++;
      if (n >= obs.size() || obs[n] != n) begin
        bad++; $display("FAIL postreset_sample[%0d] got=%0d exp=%0d", n, (n < obs.size()) ? obs[n] : -99999, n);
      end
    end
    total++; if (bus.frame_cnt !== 16'd1) begin bad++; $display("FAIL postreset_frame_cnt got=%0d exp=1", bus.frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_second_frame();
    test_saturation();
    test_backpressure();
    test_random_frames();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
